// File: rtl/ir_nec_tx.sv
// rtl/ir_nec_tx.sv - NEC infrared frame transmitter with carrier modulation and repeat code
module ir_nec_tx #(
    parameter int UNIT_CYCLES = 28125,
    parameter int CARRIER_DIV = 1316,
    parameter int GAP_UNITS   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rpt,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       irda_txd
);

    localparam int UW      = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int CW      = $clog2(CARRIER_DIV);
    localparam int SEG_MAX = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int SW      = $clog2(SEG_MAX + 1);

    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] CAR_HALF  = CW'(CARRIER_DIV / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP
    } state_t;

    state_t        state, state_n;
    logic [UW-1:0] unit_cnt, unit_n;
    logic [SW-1:0] seg_cnt, seg_n, seg_last;
    logic [4:0]    bit_cnt, bit_n;
    logic [CW-1:0] carrier_cnt, carrier_n;
    logic [31:0]   word, word_n;
    logic          rpt_q, rpt_n;
    logic          busy_n, done_n, txd_n;
    logic          unit_end, seg_end, mark_now, mark_n;

    function automatic logic is_mark(input state_t s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
    endfunction

    // Segment length in units, minus one; the current data bit sits in word[0].
    always_comb begin
        seg_last = '0;
        case (state)
            S_LEAD_MARK:  seg_last = SW'(15);
            S_LEAD_SPACE: seg_last = rpt_q ? SW'(3) : SW'(7);
            S_BIT_SPACE:  seg_last = word[0] ? SW'(2) : SW'(0);
            S_GAP:        seg_last = SW'(GAP_UNITS - 1);
            default:      seg_last = '0;
        endcase
    end

    assign unit_end = (unit_cnt == UNIT_LAST);
    assign seg_end  = unit_end && (seg_cnt == seg_last);

    always_comb begin
        state_n = state;
        unit_n  = unit_cnt;
        seg_n   = seg_cnt;
        bit_n   = bit_cnt;
        word_n  = word;
        rpt_n   = rpt_q;
        done_n  = 1'b0;
        if (state == S_IDLE) begin
            unit_n = '0;
            seg_n  = '0;
            bit_n  = '0;
            if (start) begin
                state_n = S_LEAD_MARK;
                word_n  = {~cmd, cmd, ~addr, addr};
                rpt_n   = rpt;
            end
        end else begin
            unit_n = unit_end ? '0 : unit_cnt + 1'b1;
            if (unit_end) begin
                seg_n = seg_end ? '0 : seg_cnt + 1'b1;
            end
            if (seg_end) begin
                case (state)
                    S_LEAD_MARK:  state_n = S_LEAD_SPACE;
                    S_LEAD_SPACE: state_n = rpt_q ? S_STOP_MARK : S_BIT_MARK;
                    S_BIT_MARK:   state_n = S_BIT_SPACE;
                    S_BIT_SPACE: begin
                        word_n  = {1'b0, word[31:1]};
                        bit_n   = bit_cnt + 1'b1;
                        state_n = (bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                    end
                    S_STOP_MARK:  state_n = S_GAP;
                    S_GAP: begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                    default:      state_n = S_IDLE;
                endcase
            end
        end
    end

    // Outputs are computed for the next cycle and registered, so txd never glitches.
    always_comb begin
        mark_now = is_mark(state);
        mark_n   = is_mark(state_n);
        if (mark_n && !mark_now) begin
            carrier_n = '0;
        end else if (carrier_cnt == CAR_LAST) begin
            carrier_n = '0;
        end else begin
            carrier_n = carrier_cnt + 1'b1;
        end
        txd_n  = mark_n && (carrier_n < CAR_HALF);
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            unit_cnt    <= '0;
            seg_cnt     <= '0;
            bit_cnt     <= '0;
            carrier_cnt <= '0;
            word        <= '0;
            rpt_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            irda_txd    <= 1'b0;
        end else begin
            state       <= state_n;
            unit_cnt    <= unit_n;
            seg_cnt     <= seg_n;
            bit_cnt     <= bit_n;
            carrier_cnt <= carrier_n;
            word        <= word_n;
            rpt_q       <= rpt_n;
            busy        <= busy_n;
            done        <= done_n;
            irda_txd    <= txd_n;
        end
    end

endmodule

// File: tb/tb_ir_nec_tx.sv
// tb/tb_ir_nec_tx.sv - self-checking bench for ir_nec_tx against a segment-list reference model
module tb_ir_nec_tx;

    localparam int UNIT = 8;
    localparam int DIV  = 4;
    localparam int GAP  = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rpt   = 1'b0;
    logic [7:0] addr  = 8'h00;
    logic [7:0] cmd   = 8'h00;
    logic       busy, done, irda_txd;

    int n_pass  = 0;
    int n_total = 0;
    bit trace[$];
    bit exp_txd[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] c;
        bit         r;
        bit         spam;
        int         exp_len;
    } vec_t;

    vec_t vecs[8];

    ir_nec_tx #(.UNIT_CYCLES(UNIT), .CARRIER_DIV(DIV), .GAP_UNITS(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .rpt(rpt),
        .addr(addr), .cmd(cmd), .busy(busy), .done(done), .irda_txd(irda_txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic push_mark(input int units);
        for (int i = 0; i < units * UNIT; i++) exp_txd.push_back((i % DIV) < (DIV / 2));
    endtask

    task automatic push_space(input int units);
        for (int i = 0; i < units * UNIT; i++) exp_txd.push_back(1'b0);
    endtask

    // Reference: the frame as a list of mark/space segments, expanded to one sample per clock.
    task automatic model_frame(input logic [7:0] a, input logic [7:0] c, input bit r);
        logic [31:0] w;
        w = {~c, c, ~a, a};
        exp_txd.delete();
        push_mark(16);
        push_space(r ? 4 : 8);
        if (!r) begin
            for (int i = 0; i < 32; i++) begin
                push_mark(1);
                push_space(w[i] ? 3 : 1);
            end
        end
        push_mark(1);
        push_space(GAP);
    endtask

    function automatic int frame_units(input logic [7:0] a, input logic [7:0] c, input bit r);
        logic [31:0] w;
        int u;
        w = {~c, c, ~a, a};
        u = 16 + (r ? 4 : 8) + 1 + GAP;
        if (!r) for (int i = 0; i < 32; i++) u += 1 + (w[i] ? 3 : 1);
        return u;
    endfunction

    // Entered just after the accepting edge; returns at the negedge of the done cycle.
    task automatic measure_frame(input logic [7:0] a, input logic [7:0] c, input bit r,
                                 input bit spam, input int exp_len);
        int cnt, mism, z;
        int runs[$];
        logic [31:0] got;
        model_frame(a, c, r);
        trace.delete();
        cnt = 0;
        @(negedge clk);
        while (busy === 1'b1 && cnt < 3000) begin
            trace.push_back(irda_txd);
            cnt++;
            if (spam) begin
                start = 1'b1;
                addr  = 8'($urandom);
                cmd   = 8'($urandom);
                rpt   = 1'($urandom);
            end
            @(negedge clk);
        end
        if (spam) start = 1'b0;
        check("busy_len", cnt, exp_len);
        check("model_len", exp_txd.size(), exp_len);
        mism = (trace.size() > exp_txd.size()) ? trace.size() - exp_txd.size()
                                               : exp_txd.size() - trace.size();
        for (int i = 0; i < trace.size() && i < exp_txd.size(); i++)
            if (trace[i] != exp_txd[i]) mism++;
        check("wave_mismatches", mism, 0);
        check("done_pulse", done, 1'b1);
        check("txd_idle", irda_txd, 1'b0);
        if (!r) begin
            z = 0;
            foreach (trace[i]) begin
                if (trace[i] == 1'b0) z++;
                else begin
                    if (z >= UNIT) runs.push_back(z);
                    z = 0;
                end
            end
            if (z >= UNIT) runs.push_back(z);
            got = '0;
            if (runs.size() >= 33)
                for (int i = 0; i < 32; i++) got[i] = (runs[i+1] > 2 * UNIT);
            check("decoded_word", got, {~c, c, ~a, a});
        end
    endtask

    task automatic run_frame(input vec_t v);
        @(posedge clk);
        #1;
        start = 1'b1;
        addr  = v.a;
        cmd   = v.c;
        rpt   = v.r;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        measure_frame(v.a, v.c, v.r, v.spam, v.exp_len);
        @(negedge clk);
        check("done_width", done, 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        int ones, dcount;
        vec_t v;

        vecs[0] = '{8'h00, 8'h01, 1'b0, 1'b0, 1000};
        vecs[1] = '{8'h12, 8'h34, 1'b1, 1'b0, 200};
        vecs[2] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1000};
        vecs[3] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 1000};
        for (int i = 4; i < 8; i++) begin
            vecs[i].a       = 8'($urandom);
            vecs[i].c       = 8'($urandom);
            vecs[i].r       = ($urandom_range(0, 3) == 0);
            vecs[i].spam    = 1'($urandom);
            vecs[i].exp_len = frame_units(vecs[i].a, vecs[i].c, vecs[i].r) * UNIT;
        end

        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_txd", irda_txd, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i]);
            if (i == 0) begin
                for (int k = 0; k < 8; k++) pat[7-k] = trace[k];
                check("lead_mark_start", pat, 8'b1100_1100);
                ones = 0;
                for (int k = 128; k < 192; k++) ones += trace[k];
                check("lead_space_zero", ones, 0);
                for (int k = 0; k < 8; k++) pat[7-k] = trace[192+k];
                check("bit_mark_wave", pat, 8'b1100_1100);
            end
        end

        // start held high: second frame must launch from the done cycle
        @(posedge clk);
        #1;
        start = 1'b1; addr = 8'h5A; cmd = 8'hC3; rpt = 1'b0;
        @(posedge clk);
        #1;
        measure_frame(8'h5A, 8'hC3, 1'b0, 1'b0, 1000);
        addr = 8'h81; cmd = 8'h7E; rpt = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_busy", busy, 1'b1);
        check("b2b_txd", irda_txd, 1'b1);
        measure_frame(8'h81, 8'h7E, 1'b1, 1'b0, 200);
        start = 1'b0;
        @(negedge clk);
        check("b2b_done_width", done, 1'b0);

        // reset mid-frame
        @(posedge clk);
        #1;
        start = 1'b1; addr = 8'h00; cmd = 8'h01; rpt = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_txd", irda_txd, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no_done_after_reset", dcount, 0);
        check("idle_after_reset", busy, 1'b0);
        v = '{8'h00, 8'h01, 1'b0, 1'b0, 1000};
        run_frame(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
